// File: rtl/modulo_controlador_contador_7_bits.sv
// Sequencer for a 7-bit ascending counter: clears it, enables it for a
// programmed number of edges (1..128), supports pause/abort and pulses
// fim for one cycle when the run completes.
module modulo_controlador_contador_7_bits (
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic       pause,
    input  logic       stop,
    input  logic [6:0] limite,
    input  logic [6:0] q_contador,
    output logic       en_contador,
    output logic       clr_contador,
    output logic       fim,
    output logic       ocupado,
    output logic [2:0] estado
);

    // One-hot state: each bit is its own flop so the counter-facing
    // outputs can be taken straight from a register bit.
    typedef enum logic [4:0] {
        S_OCIOSO    = 5'b00001,
        S_LIMPANDO  = 5'b00010,
        S_CONTANDO  = 5'b00100,
        S_PAUSADO   = 5'b01000,
        S_CONCLUIDO = 5'b10000
    } state_t;

    state_t     state_q;
    logic [6:0] limite_q;
    logic       term;

    // Last counting cycle: the counter is one below the limit. The 7-bit
    // wrap makes a limit of 0 terminate at q = 127, i.e. a 128-count run.
    assign term = (q_contador == (limite_q - 7'd1));

    // State transitions in priority order; limit latched only on run start.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= S_OCIOSO;
            limite_q <= 7'd0;
        end else begin
            case (state_q)
                S_OCIOSO: begin
                    if (start) begin
                        state_q  <= S_LIMPANDO;
                        limite_q <= limite;
                    end
                end
                S_LIMPANDO: begin
                    if (stop) state_q <= S_OCIOSO;
                    else      state_q <= S_CONTANDO;
                end
                S_CONTANDO: begin
                    if (stop)       state_q <= S_OCIOSO;
                    else if (term)  state_q <= S_CONCLUIDO;
                    else if (pause) state_q <= S_PAUSADO;
                end
                S_PAUSADO: begin
                    if (stop)        state_q <= S_OCIOSO;
                    else if (!pause) state_q <= S_CONTANDO;
                end
                S_CONCLUIDO: state_q <= S_OCIOSO;
                // Any corrupted encoding falls back to idle.
                default:     state_q <= S_OCIOSO;
            endcase
        end
    end

    // Counter controls and completion pulse come directly from state flops.
    assign clr_contador = state_q[1];
    assign en_contador  = state_q[2];
    assign fim          = state_q[4];
    assign ocupado      = ~state_q[0];

    // Binary state code for debug/display.
    always_comb begin
        estado = 3'd0;
        case (state_q)
            S_OCIOSO:    estado = 3'd0;
            S_LIMPANDO:  estado = 3'd1;
            S_CONTANDO:  estado = 3'd2;
            S_PAUSADO:   estado = 3'd3;
            S_CONCLUIDO: estado = 3'd4;
            default:     estado = 3'd0;
        endcase
    end

endmodule

// File: doc/modulo_controlador_contador_7_bits.md
# modulo_controlador_contador_7_bits

Sequencer for the 7-bit synchronous ascending T-flip-flop counter. Clears the counter, enables it for a programmed number of clock edges (1–128), and supports pause and abort. Signals completion with a one-cycle pulse. Sits between the user command inputs (start/pause/stop buttons, already debounced and synchronised) and the counter's count-enable and clear pins; it reads the counter's `q` back.

## Interface
Parameters: none (width fixed at 7 bits).

Ports:
- `clk`  in  1  system clock; rising-edge active; shared with the counter.
- `clr`  in  1  asynchronous reset, active-high.
- `start`  in  1  level. Sampled only in OCIOSO; begins a run.
- `pause`  in  1  level. While high in CONTANDO/PAUSADO, counting is held.
- `stop`  in  1  level. Aborts any run; highest priority.
- `limite`  in  7  terminal value. Latched on accepted `start`; 0 means 128.
- `q_contador`  in  7  counter output fed back.
- `en_contador`  out  1  to counter `input_primeiro_ff` (count enable).
- `clr_contador`  out  1  to counter clear, active-high, one-cycle pulse.
- `fim`  out  1  one-cycle run-complete pulse.
- `ocupado`  out  1  high in any state other than OCIOSO.
- `estado`  out  3  binary state code, for debug and display.

## Operation
- States and `estado` codes:
  - OCIOSO = 0
  - LIMPANDO = 1
  - CONTANDO = 2
  - PAUSADO = 3
  - CONCLUIDO = 4
- State register is one-hot.
- `en_contador`, `clr_contador` and `fim` are taken directly from state flops:
  - `en_contador` = CONTANDO
  - `clr_contador` = LIMPANDO
  - `fim` = CONCLUIDO
- These three outputs are glitch-free; no combinational decode may drive them.
- `limite_reg` (7 bits) is loaded only on OCIOSO→LIMPANDO.
- Terminal condition: `term` = (`q_contador` == `limite_reg` − 1), mod 128. So `limite_reg` = 0 gives `term` at q = 127.
- Transitions are evaluated in priority order, top first:
  - `stop`=1 in LIMPANDO/CONTANDO/PAUSADO → OCIOSO. The counter is not cleared; `fim` is not pulsed.
  - OCIOSO: `start`=1 → LIMPANDO and latch `limite`; otherwise stay.
  - LIMPANDO: → CONTANDO unconditionally (exactly one cycle).
  - CONTANDO:
    - `term`=1 → CONCLUIDO. `term` beats `pause`.
    - else `pause`=1 → PAUSADO.
    - else stay.
  - PAUSADO: `pause`=0 → CONTANDO; otherwise stay.
  - CONCLUIDO: → OCIOSO unconditionally (exactly one cycle). `stop` has no effect here.
- `start` while `ocupado`=1 is ignored. If `start` is still high on returning to OCIOSO, a new run begins on the next edge.
- Illegal one-hot state (must not occur): recover to OCIOSO on the next edge.

## Timing
- Reset (`clr`=1, async), all immediate:
  - state = OCIOSO, `limite_reg` = 0
  - `en_contador` = 0, `clr_contador` = 0, `fim` = 0, `ocupado` = 0, `estado` = 0
- Reset mid-run: the controller returns to OCIOSO at once. The counter value is left as-is.
- Run timeline, with `start` sampled high at edge E0:
  - E0 → LIMPANDO.
  - During cycle 1, `clr_contador`=1; the counter reads 0 by edge E1.
  - E1 → CONTANDO.
  - The counter increments on each edge while in CONTANDO.
- Exactly N = (`limite_reg` = 0 ? 128 : `limite_reg`) cycles are spent in CONTANDO, excluding paused cycles.
- After the final increment, `q_contador` = `limite_reg` (0 after a 128-count wrap) and holds through CONCLUIDO and OCIOSO.
- `fim` is high for the single cycle after the last increment. Start-to-`fim` latency with no pause is N+2 edges.
- Pause:
  - `pause` sampled high in CONTANDO: the counter still increments on that edge.
  - Entering PAUSADO: `en_contador`=0 from the next cycle; `q` is frozen.
  - Resume: `pause` sampled low, then counting resumes one cycle later.
- `stop` sampled in CONTANDO: the counter still increments on that same edge (enable was high), then holds.

## Test plan
- Reset and normal run:
  - Assert `clr` mid-cycle → all outputs 0 and `estado`=0 immediately, without waiting for an edge.
  - Release `clr`, then `limite`=5 with a one-cycle `start` → `clr_contador` high 1 cycle, `en_contador` high exactly 5 cycles, q ends at 5, `fim` high 1 cycle at edge E0+7, `estado` sequence 0,1,2×5,4,0.
- Edge limits:
  - `limite`=1 → 1 enable cycle, q=1, `fim` pulse.
  - `limite`=0 → 128 enable cycles, q wraps 127→0, `fim` after 130 edges.
- Pause mid-run:
  - `limite`=10; assert `pause` when q=3 and hold 4 cycles → q increments to 4 then freezes 4 cycles in PAUSADO.
  - Release `pause` → q resumes; `fim` is delayed by exactly the paused cycles; final q=10.
- Abort and ignored commands:
  - `limite`=20, `stop` at q=7 → state OCIOSO next edge, q=8 retained, no `fim`.
  - `start` pulsed during CONTANDO → ignored; `limite` changed mid-run has no effect.
- Priorities and restart:
  - `pause` high on the `term` cycle → goes to CONCLUIDO, not PAUSADO.
  - `start` held high continuously → back-to-back runs, OCIOSO held for 1 cycle between them.
  - `clr` asserted while in PAUSADO → OCIOSO immediately.
